// File: rtl/snn_pkg.sv
// Constants and types shared by the SNN layer controller and its event encoder.
package snn_pkg;

  localparam int unsigned N_NEURONS = 16;
  localparam int unsigned ADDR_W    = $clog2(N_NEURONS);

  typedef logic [ADDR_W-1:0]    neuron_addr_t;
  typedef logic [N_NEURONS-1:0] spike_vec_t;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic neuron_addr_t lowest_set_index(input spike_vec_t vec);
    neuron_addr_t idx;
    logic         found;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < int'(N_NEURONS); i++) begin
      if (vec[i] && !found) begin
        idx   = neuron_addr_t'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  // Number of set bits, sized to hold N_NEURONS.
  function automatic logic [$clog2(N_NEURONS+1)-1:0] count_ones(input spike_vec_t vec);
    logic [$clog2(N_NEURONS+1)-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(N_NEURONS); i++) begin
      cnt = cnt + ($clog2(N_NEURONS+1))'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous show-ahead FIFO; the output holds the last popped word while empty.
module event_fifo #(
  parameter int unsigned Width = 4,
  parameter int unsigned Depth = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] data_in,
  input  logic             pop,
  output logic [Width-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] PtrInc = (PtrW+1)'(1);

  logic [PtrW:0]      wr_ptr_q, rd_ptr_q;
  logic [Width-1:0]   mem_q [Depth];
  logic [Width-1:0]   last_q;
  logic               do_push, do_pop;

  // Extra MSB on each pointer distinguishes full from empty.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
               (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    data_out = empty ? last_q : mem_q[rd_ptr_q[PtrW-1:0]];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PtrInc;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrInc;
        last_q   <= mem_q[rd_ptr_q[PtrW-1:0]];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q[PtrW-1:0]] <= data_in;
    end
  end

endmodule

// File: rtl/spike_event_encoder.sv
// Captures spike vectors into a pending bitmap and serialises set bits, lowest index
// first, into address events through a small show-ahead FIFO.
module spike_event_encoder
  import snn_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DROP_W     = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 spike_valid,
  input  logic [N_NEURONS-1:0] spike,
  input  logic                 event_ready,
  output logic                 event_valid,
  output logic [ADDR_W-1:0]    event_addr,
  output logic                 idle,
  output logic                 overflow,
  output logic [DROP_W-1:0]    drop_count
);

  localparam int unsigned CntW = $clog2(N_NEURONS+1);
  localparam int unsigned SumW = ((DROP_W > CntW) ? DROP_W : CntW) + 1;

  spike_vec_t          pending_q, pending_d;
  spike_vec_t          clr, kept, dropped;
  neuron_addr_t        head_idx;
  logic                push, pop;
  logic                fifo_full, fifo_empty;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic                overflow_q, overflow_d;
  logic [CntW-1:0]     drop_cnt;
  logic [SumW-1:0]     drop_sum;

  always_comb begin
    head_idx = lowest_set_index(pending_q);
    // Full is judged on the registered state, so a same-cycle pop never frees a slot.
    push     = (pending_q != '0) && !fifo_full;
    clr      = '0;
    if (push) begin
      clr[head_idx] = 1'b1;
    end
    kept      = pending_q & ~clr;
    // A bit retired this cycle can be re-armed without counting as a drop.
    dropped   = spike_valid ? (spike & kept) : '0;
    pending_d = kept | (spike_valid ? spike : '0);

    drop_cnt = count_ones(dropped);
    drop_sum = SumW'(drop_q) + SumW'(drop_cnt);
    if (drop_sum > SumW'({DROP_W{1'b1}})) begin
      drop_d = '1;
    end else begin
      drop_d = drop_sum[DROP_W-1:0];
    end
    overflow_d = overflow_q || (dropped != '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q  <= '0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
    end
  end

  event_fifo #(
    .Width (ADDR_W),
    .Depth (FIFO_DEPTH)
  ) u_event_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .data_in  (head_idx),
    .pop      (pop),
    .data_out (event_addr),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    event_valid = !fifo_empty;
    pop         = event_valid && event_ready;
    idle        = (pending_q == '0) && fifo_empty;
    overflow    = overflow_q;
    drop_count  = drop_q;
  end

endmodule
